// File: rtl/dct_row_feeder.sv
// Pixel-stream to row packer for the 8-point DCT. Two 8-sample banks alternate:
// one fills from the pixel stream while the DCT fetches from the other.
module dct_row_feeder #(
    parameter bit LEVEL_SHIFT = 1'b1
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic [7:0] pixel_in,
    input  logic       pixel_valid,
    output logic       pixel_ready,
    input  logic [2:0] fetch_addr,
    output logic [7:0] fetch_data,
    output logic       row_valid,
    input  logic       row_done,
    output logic [2:0] row_index,
    output logic       underrun
);

    logic [7:0] r_mem [2][8];
    logic [1:0] r_full;
    logic       r_wr_bank;
    logic       r_rd_bank;
    logic [2:0] r_wr_idx;
    logic [2:0] r_row_index;
    logic       r_underrun;
    logic [7:0] r_fetch_data;

    logic       w_accept;
    logic [7:0] w_rd_sample;
    logic [7:0] w_shifted;

    assign pixel_ready = !r_full[r_wr_bank];
    assign row_valid   = r_full[r_rd_bank];
    assign w_accept    = pixel_valid && pixel_ready;
    assign row_index   = r_row_index;
    assign underrun    = r_underrun;
    assign fetch_data  = r_fetch_data;

    // Inverting the MSB is the same as subtracting 128 in two's complement.
    assign w_rd_sample = r_mem[r_rd_bank][fetch_addr];
    assign w_shifted   = LEVEL_SHIFT ? {~w_rd_sample[7], w_rd_sample[6:0]} : w_rd_sample;

    // Sample storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clock) begin
        if (w_accept)
            r_mem[r_wr_bank][r_wr_idx] <= pixel_in;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_full       <= 2'b00;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_wr_idx     <= 3'd0;
            r_row_index  <= 3'd0;
            r_underrun   <= 1'b0;
            r_fetch_data <= 8'd0;
        end else begin
            r_fetch_data <= w_shifted;
            if (w_accept) begin
                r_wr_idx <= r_wr_idx + 3'd1;
                if (r_wr_idx == 3'd7) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= ~r_wr_bank;
                end
            end
            // A full bank is never written, so the two bank indices here never collide.
            if (row_done) begin
                if (row_valid) begin
                    r_full[r_rd_bank] <= 1'b0;
                    r_rd_bank         <= ~r_rd_bank;
                    r_row_index       <= r_row_index + 3'd1;
                end else begin
                    r_underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dct_row_feeder.sv
// Bench for dct_row_feeder: row-queue reference model plus directed and random phases.
module tb_dct_row_feeder;

    logic       clock = 1'b0;
    logic       nreset = 1'b0;
    logic [7:0] pixel_in = 8'd0;
    logic       pixel_valid = 1'b0;
    logic       pixel_ready;
    logic [2:0] fetch_addr = 3'd0;
    logic [7:0] fetch_data;
    logic       row_valid;
    logic       row_done = 1'b0;
    logic [2:0] row_index;
    logic       underrun;

    logic [7:0] p1_in = 8'd0;
    logic       p1_valid = 1'b0;
    logic       p1_ready;
    logic [2:0] p1_addr = 3'd0;
    logic [7:0] p1_data;
    logic       p1_row_valid;
    logic [2:0] p1_row_index;
    logic       p1_underrun;

    dct_row_feeder #(.LEVEL_SHIFT(1'b1)) u_dut (
        .clock(clock), .nreset(nreset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
        .row_valid(row_valid), .row_done(row_done), .row_index(row_index), .underrun(underrun)
    );

    dct_row_feeder #(.LEVEL_SHIFT(1'b0)) u_raw (
        .clock(clock), .nreset(nreset), .pixel_in(p1_in), .pixel_valid(p1_valid),
        .pixel_ready(p1_ready), .fetch_addr(p1_addr), .fetch_data(p1_data),
        .row_valid(p1_row_valid), .row_done(1'b0), .row_index(p1_row_index), .underrun(p1_underrun)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Model: completed rows waiting for the DCT, in arrival order, plus the row being packed.
    logic [63:0] q[$];
    logic [63:0] part;
    int pcnt;
    int ridx;
    bit under;

    function automatic logic [7:0] lshift(input logic [7:0] p);
        return 8'(int'(p) - 128);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        part = '0;
        pcnt = 0;
        ridx = 0;
        under = 0;
    endtask

    task automatic reset_dut();
        nreset = 1'b0;
        pixel_valid = 1'b0;
        row_done = 1'b0;
        p1_valid = 1'b0;
        #10;
        nreset = 1'b1;
        model_clear();
        @(posedge clock); #1;
    endtask

    // One clock of stimulus; all checks are against the model state before the edge.
    task automatic cyc(input bit v, input logic [7:0] d, input bit rd, input logic [2:0] a,
                       output bit acc);
        bit pre_valid;
        logic [7:0] fe;
        pixel_valid = v;
        pixel_in = d;
        row_done = rd;
        fetch_addr = a;
        chk("pixel_ready", pixel_ready, q.size() < 2);
        chk("row_valid", row_valid, q.size() > 0);
        chk("row_index", row_index, ridx);
        chk("underrun", underrun, under);
        pre_valid = q.size() > 0;
        fe = pre_valid ? lshift(q[0][int'(a)*8 +: 8]) : 8'd0;
        acc = v && (q.size() < 2);
        @(posedge clock); #1;
        if (rd) begin
            if (pre_valid) begin
                void'(q.pop_front());
                ridx = (ridx + 1) % 8;
            end else begin
                under = 1;
            end
        end
        if (acc) begin
            part[pcnt*8 +: 8] = d;
            pcnt++;
            if (pcnt == 8) begin
                q.push_back(part);
                pcnt = 0;
            end
        end
        if (pre_valid) chk("fetch_data", fetch_data, fe);
        pixel_valid = 1'b0;
        row_done = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        bit acc;
        int n;
        n = 0;
        acc = 0;
        while (!acc && n < 50) begin
            cyc(1'b1, d, 1'b0, 3'd0, acc);
            n++;
        end
        if (!acc) chk("send_timeout", acc, 1);
    endtask

    initial begin
        bit acc;
        logic [7:0] vals[64];
        logic [7:0] v6[8];
        int k, dones, pix, n, at64;
        bit v, rd, pre;
        logic [2:0] a;
        logic [7:0] hold;

        model_clear();
        #12;
        chk("rst_ready", pixel_ready, 1);
        chk("rst_row_valid", row_valid, 0);
        chk("rst_fetch_data", fetch_data, 0);
        chk("rst_row_index", row_index, 0);
        chk("rst_underrun", underrun, 0);
        reset_dut();

        // 1: first row, level-shifted readback
        for (int i = 0; i < 8; i++) send(8'(i));
        chk("t1_row_valid", row_valid, 1);
        chk("t1_row_index", row_index, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'd0, 1'b0, 3'(i), acc);
            chk("t1_fetch", fetch_data, 8'h80 + 8'(i));
        end

        // 2: backpressure with both banks full
        reset_dut();
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
        chk("t2_ready_low", pixel_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h20, 1'b0, 3'd0, acc);
            chk("t2_stalled", acc, 0);
        end
        cyc(1'b1, 8'h20, 1'b1, 3'd0, acc);
        chk("t2_ready_back", pixel_ready, 1);
        cyc(1'b1, 8'h20, 1'b0, 3'd0, acc);
        chk("t2_accept17", acc, 1);
        for (int i = 18; i <= 24; i++) send(8'(8'h10 + i - 1));
        cyc(1'b0, 8'd0, 1'b1, 3'd0, acc);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'd0, 1'b0, 3'(i), acc);
            chk("t2_row2", fetch_data, lshift(8'h20 + 8'(i)));
        end

        // 3: 64 continuous random pixels, DCT consumes one row per 8 cycles
        reset_dut();
        for (int i = 0; i < 64; i++) vals[i] = 8'($urandom_range(0, 255));
        k = 0; dones = 0; pix = 0; n = 0; at64 = -1;
        while (dones < 8 && n < 300) begin
            pre = q.size() > 0;
            v = pix < 64;
            a = pre ? 3'(k) : 3'd0;
            rd = pre && (k == 7);
            cyc(v, v ? vals[pix] : 8'd0, rd, a, acc);
            n++;
            if (pre) k = (k + 1) % 8;
            if (acc) begin
                pix++;
                if (pix == 64) at64 = n;
            end
            if (rd) begin
                dones++;
                chk("t3_row_index", row_index, dones % 8);
            end
        end
        chk("t3_dones", dones, 8);
        chk("t3_throughput", at64, 64);

        // 4: row_done coincides with the 16th accept
        reset_dut();
        for (int i = 0; i < 15; i++) send(8'(8'h40 + i));
        cyc(1'b1, 8'h4F, 1'b1, 3'd0, acc);
        chk("t4_acc16", acc, 1);
        chk("t4_ready", pixel_ready, 1);
        chk("t4_row_valid", row_valid, 1);
        chk("t4_row_index", row_index, 1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'd0, 1'b0, 3'(7 - i), acc);
            chk("t4_bank1", fetch_data, lshift(8'h48 + 8'(7 - i)));
        end
        send(8'h99);

        // 5: underrun, then asynchronous reset mid-row
        reset_dut();
        cyc(1'b0, 8'd0, 1'b1, 3'd0, acc);
        chk("t5_underrun", underrun, 1);
        chk("t5_row_index", row_index, 0);
        for (int i = 0; i < 11; i++) send(8'(i * 7));
        chk("t5_row_valid_pre", row_valid, 1);
        #3;
        nreset = 1'b0;
        #1;
        chk("t5_async_underrun", underrun, 0);
        chk("t5_async_row_valid", row_valid, 0);
        chk("t5_async_fetch", fetch_data, 0);
        chk("t5_async_ready", pixel_ready, 1);
        model_clear();
        #10;
        nreset = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < 8; i++) send(8'(8'hA0 + i));
        cyc(1'b0, 8'd0, 1'b0, 3'd5, acc);
        chk("t5_after_reset", fetch_data, 8'h25);

        // 6: raw instance returns samples unmodified
        reset_dut();
        v6[0] = 8'hFF; v6[1] = 8'h80; v6[2] = 8'h00;
        for (int i = 3; i < 8; i++) v6[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) begin
            chk("t6_ready", p1_ready, 1);
            p1_valid = 1'b1;
            p1_in = v6[i];
            @(posedge clock); #1;
        end
        p1_valid = 1'b0;
        chk("t6_row_valid", p1_row_valid, 1);
        for (int i = 0; i < 8; i++) begin
            p1_addr = 3'(i);
            @(posedge clock); #1;
            chk("t6_raw", p1_data, v6[i]);
        end

        // Random traffic: source holds data until accepted
        reset_dut();
        hold = 8'($urandom_range(0, 255));
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 5) == 0);
            cyc(v, hold, rd, 3'($urandom_range(0, 7)), acc);
            if (acc) hold = 8'($urandom_range(0, 255));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
